// File: rtl/para_hit.sv
// para_hit: threshold hit detector for the ADC sample stream.
// Qualifies a hit after the sample has stayed at or above cfg_th for the
// high-dwell time. Counts ring-down crossings until the sample has stayed
// below threshold for the low-dwell time. Also keeps a block average of
// 2**AVE_SHIFT samples.
// Optional feature: define PARA_HIT_TS_EN to timestamp each hit with a
// free-running cycle counter. When it is not defined, stu_hit_ts reads 0.
module para_hit #(
  parameter int AVE_SHIFT = 4
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic [15:0] data_in,
  input  logic        data_vld,
  input  logic [15:0] cfg_th,
  input  logic [31:0] cfg_hdt,
  input  logic [31:0] cfg_ldt,
  output logic [15:0] sta_para_ave,
  output logic [15:0] stu_hit_id,
  output logic [15:0] stu_ring,
  output logic        hit_pulse,
  output logic        hit_active,
  output logic [31:0] stu_hit_ts
);

  localparam int AW = 16 + AVE_SHIFT;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HQUAL,
    ST_HIT,
    ST_LQUAL
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            above;
  logic            above_d;
  logic            rise;
  logic [31:0]     timer;
  logic [32:0]     timer_inc;
  logic [31:0]     nh;
  logic [31:0]     nl;
  logic            enter_hit;
  logic [AW-1:0]   acc;
  logic [AW-1:0]   acc_sum;
  logic [AVE_SHIFT-1:0] cnt;

  // A dwell of zero behaves as a dwell of one cycle.
  assign nh        = (cfg_hdt == 32'd0) ? 32'd1 : cfg_hdt;
  assign nl        = (cfg_ldt == 32'd0) ? 32'd1 : cfg_ldt;
  assign timer_inc = {1'b0, timer} + 33'd1;
  assign rise      = above & ~above_d;
  assign enter_hit = (state == ST_HQUAL) && (state_nxt == ST_HIT);
  assign acc_sum   = acc + {{AVE_SHIFT{1'b0}}, data_in};

  // Threshold comparison is only refreshed on valid samples; it holds between strobes.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      above   <= 1'b0;
      above_d <= 1'b0;
    end else begin
      above_d <= above;
      if (data_vld) begin
        above <= (data_in >= cfg_th);
      end
    end
  end

  // State register.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. The dwell compare is >= so lowering cfg mid-dwell fires at once.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (above) state_nxt = ST_HQUAL;
      end
      ST_HQUAL: begin
        if (!above)                      state_nxt = ST_IDLE;
        else if (timer_inc >= {1'b0, nh}) state_nxt = ST_HIT;
      end
      ST_HIT: begin
        if (!above) state_nxt = ST_LQUAL;
      end
      ST_LQUAL: begin
        if (above)                       state_nxt = ST_HIT;
        else if (timer_inc >= {1'b0, nl}) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    hit_active = (state == ST_HIT) || (state == ST_LQUAL);
  end

  // Dwell timer restarts on every state change and saturates instead of wrapping.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      timer <= 32'd0;
    end else if (state_nxt != state) begin
      timer <= 32'd0;
    end else if (timer != 32'hFFFF_FFFF) begin
      timer <= timer_inc[31:0];
    end
  end

  // Hit bookkeeping. Only a fresh qualification counts as a new hit; re-entry from LQUAL does not.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      hit_pulse  <= 1'b0;
      stu_hit_id <= 16'd0;
      stu_ring   <= 16'd0;
    end else begin
      hit_pulse <= enter_hit;
      if (enter_hit) begin
        stu_hit_id <= stu_hit_id + 16'd1;
        stu_ring   <= 16'd1;
      end else if (hit_active && rise && (stu_ring != 16'hFFFF)) begin
        stu_ring <= stu_ring + 16'd1;
      end
    end
  end

  // Block average. The last sample of a block is added in directly so the accumulator clears in the same cycle.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      acc          <= '0;
      cnt          <= '0;
      sta_para_ave <= 16'd0;
    end else if (data_vld) begin
      if (cnt == {AVE_SHIFT{1'b1}}) begin
        sta_para_ave <= acc_sum[AVE_SHIFT +: 16];
        acc          <= '0;
        cnt          <= '0;
      end else begin
        acc <= acc_sum;
        cnt <= cnt + AVE_SHIFT'(1);
      end
    end
  end

`ifdef PARA_HIT_TS_EN
  logic [31:0] ts_cnt;

  // Free-running cycle counter. The value latched is the count in the hit_pulse cycle.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt     <= 32'd0;
      stu_hit_ts <= 32'd0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (enter_hit) begin
        stu_hit_ts <= ts_cnt + 32'd1;
      end
    end
  end
`else
  assign stu_hit_ts = 32'd0;
`endif

endmodule

// File: tb/tb_para_hit.sv
// tb_para_hit: self-checking bench for para_hit.
// A behavioural model tracks phase, dwell age, hit count, ring count and the
// sample window. A compare process checks every output against the model on
// each falling edge. Directed scenarios pin both the model and the DUT with
// hand-computed literals. These are followed by a randomized run.
module tb_para_hit;

  localparam int AVE_SHIFT = 4;
  localparam int BLOCK     = 2 ** AVE_SHIFT;
  localparam int P_IDLE    = 0;
  localparam int P_HQ      = 1;
  localparam int P_HIT     = 2;
  localparam int P_LQ      = 3;

  logic        clk_sys = 1'b0;
  logic        rst_n   = 1'b0;
  logic [15:0] data_in;
  logic        data_vld;
  logic [15:0] cfg_th;
  logic [31:0] cfg_hdt;
  logic [31:0] cfg_ldt;
  logic [15:0] sta_para_ave;
  logic [15:0] stu_hit_id;
  logic [15:0] stu_ring;
  logic        hit_pulse;
  logic        hit_active;
  logic [31:0] stu_hit_ts;

  int total  = 0;
  int bad    = 0;
  bit cmp_en = 1'b0;

  // Reference model state.
  int          m_phase;
  longint      m_age;
  bit          m_above;
  bit          m_above_d;
  int          m_ring;
  int          m_hit_id;
  bit          m_pulse;
  int          m_ave;
  int unsigned m_cyc;
  int unsigned m_ts;
  int unsigned m_win[$];

  para_hit #(.AVE_SHIFT(AVE_SHIFT)) dut (
    .clk_sys      (clk_sys),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .data_vld     (data_vld),
    .cfg_th       (cfg_th),
    .cfg_hdt      (cfg_hdt),
    .cfg_ldt      (cfg_ldt),
    .sta_para_ave (sta_para_ave),
    .stu_hit_id   (stu_hit_id),
    .stu_ring     (stu_ring),
    .hit_pulse    (hit_pulse),
    .hit_active   (hit_active),
    .stu_hit_ts   (stu_hit_ts)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit vld, input logic [15:0] d);
    data_vld = vld;
    data_in  = d;
  endtask

  task automatic model_reset();
    m_phase   = P_IDLE;
    m_age     = 1;
    m_above   = 1'b0;
    m_above_d = 1'b0;
    m_ring    = 0;
    m_hit_id  = 0;
    m_pulse   = 1'b0;
    m_ave     = 0;
    m_cyc     = 0;
    m_ts      = 0;
    m_win.delete();
  endtask

  // One clock edge of the specified behaviour, from the pre-edge view.
  task automatic model_step();
    bit          rise;
    longint      nh;
    longint      nl;
    int          nxt;
    int unsigned sum;
    rise = m_above && !m_above_d;
    nh   = (cfg_hdt == 32'd0) ? 64'd1 : {32'd0, cfg_hdt};
    nl   = (cfg_ldt == 32'd0) ? 64'd1 : {32'd0, cfg_ldt};
    nxt  = m_phase;
    case (m_phase)
      P_IDLE:  if (m_above) nxt = P_HQ;
      P_HQ:    if (!m_above) nxt = P_IDLE; else if (m_age >= nh) nxt = P_HIT;
      P_HIT:   if (!m_above) nxt = P_LQ;
      default: if (m_above) nxt = P_HIT; else if (m_age >= nl) nxt = P_IDLE;
    endcase
    m_cyc   = m_cyc + 1;
    m_pulse = (m_phase == P_HQ) && (nxt == P_HIT);
    if (m_pulse) begin
      m_hit_id = (m_hit_id + 1) % 65536;
      m_ring   = 1;
      m_ts     = m_cyc;
    end else if ((m_phase == P_HIT || m_phase == P_LQ) && rise && m_ring < 65535) begin
      m_ring = m_ring + 1;
    end
    m_age     = (nxt != m_phase) ? 1 : m_age + 1;
    m_phase   = nxt;
    m_above_d = m_above;
    if (data_vld) begin
      m_above = (data_in >= cfg_th);
      m_win.push_back(int'(data_in));
      if (m_win.size() == BLOCK) begin
        sum = 0;
        foreach (m_win[i]) sum += m_win[i];
        m_ave = int'(sum / BLOCK);
        m_win.delete();
      end
    end
  endtask

  // Model follows the DUT clock and asynchronous reset.
  initial begin
    model_reset();
    forever begin
      @(posedge clk_sys or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Continuous comparison against the model on every falling edge.
  initial begin
    logic [31:0] exp_ts;
    forever begin
      @(negedge clk_sys);
      if (cmp_en && rst_n) begin
`ifdef PARA_HIT_TS_EN
        exp_ts = m_ts;
`else
        exp_ts = 32'd0;
`endif
        checkOutput("ave",    32'(sta_para_ave), 32'(m_ave));
        checkOutput("hit_id", 32'(stu_hit_id),   32'(m_hit_id));
        checkOutput("ring",   32'(stu_ring),     32'(m_ring));
        checkOutput("pulse",  32'(hit_pulse),    32'(m_pulse));
        checkOutput("active", 32'(hit_active),   32'(m_phase == P_HIT || m_phase == P_LQ));
        checkOutput("hit_ts", stu_hit_ts,        exp_ts);
      end
    end
  end

  initial begin
    int npulse;
    bit lvl;
    applyStimulus(1'b0, 16'h0000);
    cfg_th  = 16'h8000;
    cfg_hdt = 32'd3;
    cfg_ldt = 32'd8;
    repeat (3) @(negedge clk_sys);
    checkOutput("rst_ave",    32'(sta_para_ave), 32'h0);
    checkOutput("rst_hit_id", 32'(stu_hit_id),   32'h0);
    checkOutput("rst_ring",   32'(stu_ring),     32'h0);
    checkOutput("rst_pulse",  32'(hit_pulse),    32'h0);
    checkOutput("rst_active", 32'(hit_active),   32'h0);
    checkOutput("rst_ts",     stu_hit_ts,        32'h0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Block average: 16 samples of 0x1000, result one cycle after the last.
    for (int j = 0; j <= 16; j++) begin
      @(negedge clk_sys);
      if (j == 15) checkOutput("ave_early", 32'(sta_para_ave), 32'h0);
      if (j == 16) begin
        checkOutput("ave_block",   32'(sta_para_ave), 32'h1000);
        checkOutput("model_ave",   32'(m_ave),        32'h1000);
        checkOutput("ave_hit_id",  32'(stu_hit_id),   32'h0);
      end
      applyStimulus(j < 16, 16'h1000);
    end

    // Qualified hit with cfg_hdt=3: pulse 5 cycles after the first above sample.
    for (int j = 0; j < 8; j++) begin
      @(negedge clk_sys);
      checkOutput("t2_pulse", 32'(hit_pulse), 32'(j == 5));
      applyStimulus(1'b1, 16'h9000);
    end
    @(negedge clk_sys);
    checkOutput("t2_hit_id",   32'(stu_hit_id), 32'h1);
    checkOutput("t2_ring",     32'(stu_ring),   32'h1);
    checkOutput("t2_active",   32'(hit_active), 32'h1);
    checkOutput("model_hitid", 32'(m_hit_id),   32'h1);

    // Ring-down: two short dips then a full 8-cycle release.
    npulse = 0;
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 0; k < 7; k++) begin
        applyStimulus(1'b1, (k < 4) ? 16'h7000 : 16'h9000);
        @(negedge clk_sys);
        if (hit_pulse) npulse++;
      end
    end
    for (int j = 0; j < 12; j++) begin
      if (j > 0) @(negedge clk_sys);
      if (hit_pulse) npulse++;
      if (j == 9)  checkOutput("t4_active_lq", 32'(hit_active), 32'h1);
      if (j == 10) checkOutput("t4_active_rel", 32'(hit_active), 32'h0);
      applyStimulus(1'b1, 16'h7000);
    end
    @(negedge clk_sys);
    checkOutput("t4_ring",     32'(stu_ring),   32'h3);
    checkOutput("model_ring",  32'(m_ring),     32'h3);
    checkOutput("t4_hit_id",   32'(stu_hit_id), 32'h1);
    checkOutput("t4_pulses",   32'(npulse),     32'h0);

    // Short excursion with cfg_hdt=10 never qualifies.
    cfg_hdt = 32'd10;
    npulse  = 0;
    for (int j = 0; j < 17; j++) begin
      applyStimulus(1'b1, (j < 5) ? 16'h9000 : 16'h7000);
      @(negedge clk_sys);
      if (hit_pulse) npulse++;
    end
    checkOutput("t3_pulses", 32'(npulse),     32'h0);
    checkOutput("t3_hit_id", 32'(stu_hit_id), 32'h1);

    // cfg_hdt=0 behaves as one cycle: pulse 3 cycles after the sample.
    cfg_hdt = 32'd0;
    for (int j = 0; j < 7; j++) begin
      if (j > 0) begin
        @(negedge clk_sys);
        checkOutput("t5_pulse", 32'(hit_pulse), 32'(j == 3));
      end
      applyStimulus(1'b1, 16'h9000);
    end
    checkOutput("t5_hit_id", 32'(stu_hit_id), 32'h2);

    // Asynchronous reset in the middle of LQUAL.
    cfg_ldt = 32'd20;
    for (int j = 0; j < 6; j++) begin
      applyStimulus(1'b1, 16'h7000);
      @(negedge clk_sys);
    end
    checkOutput("t6_in_lq", 32'(hit_active), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_ave",    32'(sta_para_ave), 32'h0);
    checkOutput("t6_hit_id", 32'(stu_hit_id),   32'h0);
    checkOutput("t6_ring",   32'(stu_ring),     32'h0);
    checkOutput("t6_pulse",  32'(hit_pulse),    32'h0);
    checkOutput("t6_active", 32'(hit_active),   32'h0);
    checkOutput("t6_ts",     stu_hit_ts,        32'h0);
    @(negedge clk_sys);
    rst_n = 1'b1;

    // Randomized run with live cfg changes and threshold-boundary samples.
    cfg_hdt = 32'd2;
    cfg_ldt = 32'd3;
    lvl     = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk_sys);
      if (c == 2000) begin
        #2 rst_n = 1'b0;
        @(negedge clk_sys);
        rst_n = 1'b1;
      end
      if ($urandom_range(0, 99) < 3) cfg_hdt = $urandom_range(0, 6);
      if ($urandom_range(0, 99) < 3) cfg_ldt = $urandom_range(0, 6);
      if ($urandom_range(0, 5) == 0) lvl = ~lvl;
      if ($urandom_range(0, 9) == 0)
        applyStimulus($urandom_range(0, 3) != 0, lvl ? cfg_th : cfg_th - 16'd1);
      else if (lvl)
        applyStimulus($urandom_range(0, 3) != 0, 16'($urandom_range(32'h8000, 32'hFFFF)));
      else
        applyStimulus($urandom_range(0, 3) != 0, 16'($urandom_range(0, 32'h7FFF)));
    end
    @(negedge clk_sys);
    cmp_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
